// File: rtl/tic_countdown.sv
// tic_countdown: programmable countdown timer driven by a 1-cycle timebase
// strobe. A duration (in tics) is held in a reload register, counted down to
// zero one tic at a time, and expiry raises a one-cycle pulse. The count can
// optionally restart from the reload value on expiry.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   tic_i          1-cycle timebase strobe
//   load_i         capture duration_i into the reload register (IDLE/DONE only)
//   duration_i     countdown length in tics, unsigned
//   start_i        begin counting (IDLE/DONE only)
//   pause_i        level, freezes counting while high
//   abort_i        cancel countdown, return to IDLE
//   auto_reload_i  level, sampled at expiry
//   remaining_o    current count value
//   busy_o         counting or paused
//   done_o         countdown finished, waiting for start/abort
//   expired_o      one-cycle pulse per expiry
//
// state | meaning
// IDLE  | no countdown active, remaining is 0
// RUN   | counting tics down
// HOLD  | paused, remaining frozen
// DONE  | countdown finished, holds until start or abort
module tic_countdown #(
  parameter int N = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tic_i,
  input  logic         load_i,
  input  logic [N-1:0] duration_i,
  input  logic         start_i,
  input  logic         pause_i,
  input  logic         abort_i,
  input  logic         auto_reload_i,
  output logic [N-1:0] remaining_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         expired_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] remaining_q, remaining_d;
  logic [N-1:0] reload_q, reload_d;
  logic         expired_q, expired_d;

  logic         accept_cmd;
  logic [N-1:0] start_val;

  // start/load are only honoured when no countdown is in progress
  assign accept_cmd = (state_q == ST_IDLE) || (state_q == ST_DONE);
  // a load in the same cycle as start takes effect immediately
  assign start_val  = load_i ? duration_i : reload_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    expired_d   = 1'b0;

    if (abort_i) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
    end else if (start_i && accept_cmd) begin
      if (load_i) reload_d = duration_i;
      if (start_val != '0) begin
        remaining_d = start_val;
        state_d     = ST_RUN;
      end else begin
        // zero-length countdown expires immediately
        remaining_d = '0;
        expired_d   = 1'b1;
        state_d     = ST_DONE;
      end
    end else if (load_i && accept_cmd) begin
      reload_d = duration_i;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause_i) begin
            state_d = ST_HOLD;
          end else if (tic_i) begin
            if (remaining_q > {{(N-1){1'b0}}, 1'b1}) begin
              remaining_d = remaining_q - 1'b1;
            end else if (remaining_q != '0) begin
              expired_d = 1'b1;
              // a zero reload value would never expire again, so stop instead
              if (auto_reload_i && (reload_q != '0)) begin
                remaining_d = reload_q;
              end else begin
                remaining_d = '0;
                state_d     = ST_DONE;
              end
            end
          end
        end
        ST_HOLD: begin
          if (!pause_i) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      reload_q    <= '0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      expired_q   <= expired_d;
    end
  end

  assign remaining_o = remaining_q;
  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign done_o      = (state_q == ST_DONE);
  assign expired_o   = expired_q;

endmodule

// File: doc/tic_countdown.md
# tic_countdown

Programmable countdown timer that consumes the 1-cycle `tic` strobe produced by the free-running counter/timer (one tic per 100000 clocks, 1 ms at 100 MHz). A duration in tics is loaded, then counted down, one tic at a time, to zero. Expiry raises a one-cycle `expired` pulse, with optional automatic reload. The block sits beside the tic generator and feeds timeouts, periodic events and display refresh logic.

## Interface
- `N`, default 16: width of duration, reload and remaining registers.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `tic` input 1: 1-cycle timebase strobe; any width-1 pulse per tic period.
- `load` input 1: capture `duration` into the reload register.
- `duration` input N: countdown length in tics, unsigned.
- `start` input 1: begin counting from the reload value.
- `pause` input 1: level; freezes counting while high.
- `abort` input 1: cancel any countdown, return to IDLE.
- `auto_reload` input 1: level, sampled at expiry; reload and continue instead of stopping.
- `remaining` output N: current count value (registered).
- `busy` output 1: high in RUN or HOLD.
- `done` output 1: high in DONE.
- `expired` output 1: registered 1-cycle pulse per expiry.

## Operation
- States: IDLE, RUN, HOLD, DONE. Encoded and registered; `busy` and `done` are decoded from the state register.
- Per-cycle priority: `rst` > `abort` > `start` > `load` > `tic`/`pause` handling.
- `abort`, any state: next state IDLE, `remaining` <= 0, `expired` <= 0. The reload register is kept.
- `load` is accepted only in IDLE or DONE: reload <= `duration`. It is ignored in RUN and HOLD. It does not change `remaining` or state.
- `start` is accepted only in IDLE or DONE; it is ignored while busy. The start value is `duration` if `load` is high in the same cycle, otherwise the reload register. If `load` is also high, reload <= `duration`.
  - Start value != 0: `remaining` <= start value, next state RUN.
  - Start value == 0: `remaining` <= 0, `expired` <= 1, next state DONE.
- RUN, `pause` high: next state HOLD. A tic in that cycle is ignored.
- RUN, `pause` low, `tic` high:
  - If `remaining` > 1: `remaining` <= `remaining` - 1.
  - If `remaining` == 1: `expired` <= 1. Then, if `auto_reload`: `remaining` <= reload, stay RUN. Otherwise: `remaining` <= 0, next state DONE.
- HOLD: tics ignored and `remaining` held. Next state RUN when `pause` is low.
- DONE: holds until `start` or `abort`. Tics ignored.
- Arithmetic is unsigned, N bits. `remaining` never wraps below 0; the decrement path is never taken at 0.
- Maximum duration 2^N-1 tics. Reload value 0 with `auto_reload` at expiry: `remaining` <= 0, next state DONE (no reload of zero).

## Timing
- Reset values: state IDLE, `remaining` 0, reload 0, `expired` 0, `busy` 0, `done` 0.
- Reset mid-countdown: everything returns to the reset values at the next edge. No `expired` pulse.
- Start latency: `start` sampled at edge k → `busy` and `remaining` = D valid after edge k. A tic coincident with `start` is not counted.
- Decrement latency: a counted tic at edge k → `remaining` updated after edge k.
- Expiry: the final counted tic at edge k → `expired` high for exactly the cycle after edge k. In the same cycle `done` is high, or `remaining` = reload when auto-reloading.
- Counting rule: a tic is counted only when the state is RUN and `pause` is low in the same cycle.
- Period with auto-reload: exactly D tics between consecutive `expired` pulses.
- Back-to-back tics on consecutive cycles are each counted. The block does not assume tic spacing.
- `abort` coincident with the final tic: the abort wins and no `expired` pulse is produced.

## Test plan
- **Reset:** assert `rst` 2 cycles mid-RUN with `remaining` = 7 → all outputs 0, state IDLE, no `expired`.
- **Basic countdown:** `load`+`start` with `duration` = 3, then 3 tics spaced 10 clocks apart.
  - `remaining` steps 3→2→1→0.
  - `expired` is high for 1 cycle after the third tic, then `done` = 1 and `busy` = 0.
- **Auto-reload:** `duration` = 2, `auto_reload` = 1, 6 tics → `expired` after tics 2, 4 and 6; `remaining` returns to 2 after each expiry; state stays RUN.
- **Pause:** `duration` = 5, 2 tics, then `pause` high during 3 tics, then low and 3 tics.
  - `remaining` holds at 3 while HOLD.
  - Expiry occurs after the 5th counted tic.
- **Boundary cases:**
  - `start` with a zero reload → `expired` pulse and `done`, with `remaining` = 0.
  - `start` while RUN → ignored.
  - `load` while RUN → reload unchanged.
  - Tic coincident with `start` → not counted.
- **Abort:** `abort` in the same cycle as the final tic (`remaining` = 1) → IDLE, `remaining` = 0, no `expired`. Reload is retained: the next `start` counts the same D.
